tlp_frag_ctrl: RTL and testbench

TLP_FRAG_CTRL -- requirements
Module: tlp_frag_ctrl

---
 rtl/data_frag_package.sv | 23 ++
 rtl/tlp_frag_ctrl_if.sv | 22 ++
 rtl/tlp_frag_out_stage.sv | 64 ++++++
 rtl/tlp_frag_ctrl.sv | 159 +++++++++++++++
 tb/tb_tlp_frag_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_frag_package.sv
// Shared types for the TLP fragmenter: source tags, FSM states and beat geometry.
package data_frag_package;

   typedef enum logic [2:0] {
      NO_SOURCE = 3'd0,
      PH        = 3'd1,
      PD        = 3'd2,
      NPH       = 3'd3,
      NPD       = 3'd4,
      CPLH      = 3'd5,
      CPLD      = 3'd6
   } Tx_Arbiter_Sources_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TAG_WAIT = 2'd1,
      HDR      = 2'd2,
      DATA     = 2'd3
   } frag_state_t;

   localparam int BEAT_DW = 4;

endpackage

// File: rtl/tlp_frag_ctrl_if.sv
// DLL-side beat bus. valid/ready: a beat moves when dll_valid && dll_ready at a rising
// clk edge; while dll_valid is high and dll_ready low, data/sop/eop/last_dw hold stable.
interface tlp_frag_ctrl_if #(
   parameter int DATA_WIDTH = 128
);
   logic                  dll_valid;
   logic                  dll_ready;
   logic [DATA_WIDTH-1:0] dll_data;
   logic                  dll_sop;
   logic                  dll_eop;
   logic [1:0]            dll_last_dw;

   modport master (
      output dll_valid, dll_data, dll_sop, dll_eop, dll_last_dw,
      input  dll_ready
   );

   modport slave (
      input  dll_valid, dll_data, dll_sop, dll_eop, dll_last_dw,
      output dll_ready
   );
endinterface

// File: rtl/tlp_frag_out_stage.sv
// Single output register towards the DLL; holds a beat until the DLL accepts it.
module tlp_frag_out_stage #(
   parameter int DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_sop,
   input  logic                  in_eop,
   input  logic [1:0]            in_last_dw,
   tlp_frag_ctrl_if.master       dll
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  sop_q, sop_d;
   logic                  eop_q, eop_d;
   logic [1:0]            last_dw_q, last_dw_d;

   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      last_dw_d = last_dw_q;
      if (load) begin
         valid_d   = 1'b1;
         data_d    = in_data;
         sop_d     = in_sop;
         eop_d     = in_eop;
         last_dw_d = in_last_dw;
      end else if (dll.dll_ready) begin
         // Drained: drop framing flags so an idle bus never shows a stale eop.
         valid_d   = 1'b0;
         sop_d     = 1'b0;
         eop_d     = 1'b0;
         last_dw_d = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         last_dw_q <= 2'b00;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         last_dw_q <= last_dw_d;
      end
   end

   assign dll.dll_valid   = valid_q;
   assign dll.dll_data    = data_q;
   assign dll.dll_sop     = sop_q;
   assign dll.dll_eop     = eop_q;
   assign dll.dll_last_dw = last_dw_q;

endmodule

// File: rtl/tlp_frag_ctrl.sv
// Pops source tags from the sequence recorder and streams each TLP as 4-DW beats to the DLL.
// Optional build macro FRAG_PREFETCH_EN: fetch the next tag during the eop transfer.
module tlp_frag_ctrl
   import data_frag_package::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int LEN_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  arst,
   output logic                  seq_rd_en,
   output logic [1:0]            seq_rd_mode,
   input  Tx_Arbiter_Sources_t   seq_rd_data_1,
   input  logic                  seq_empty,
   output Tx_Arbiter_Sources_t   src_sel,
   output logic                  src_rd_en,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   input  logic [LEN_WIDTH-1:0]  src_len,
   tlp_frag_ctrl_if.master       dll,
   output logic                  start_fragment,
   output logic                  tag_err,
   output frag_state_t           dbg_state
);

   frag_state_t           state_q, state_d;
   Tx_Arbiter_Sources_t   src_sel_q, src_sel_d;
   logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
   logic [1:0]            last_dw_q, last_dw_d;
   logic                  tag_err_q, tag_err_d;
   logic                  start_fragment_q, start_fragment_d;

   logic                  xfer;
   logic                  eop_xfer;
   logic                  out_sop;
   logic                  out_eop;
   logic [1:0]            out_last_dw;
   logic [LEN_WIDTH+1:0]  len_plus3;
   logic [LEN_WIDTH-1:0]  hdr_beats_left;
   logic [1:0]            hdr_last_dw;

   assign len_plus3      = {2'b00, src_len} + (LEN_WIDTH+2)'(BEAT_DW - 1);
   assign hdr_beats_left = len_plus3[LEN_WIDTH+1:2] - LEN_WIDTH'(1);
   assign hdr_last_dw    = src_len[1:0] - 2'd1;

   assign xfer = ((state_q == HDR) || (state_q == DATA)) && src_valid &&
                 (!dll.dll_valid || dll.dll_ready) && !arst;

   always_comb begin
      state_d      = state_q;
      src_sel_d    = src_sel_q;
      beats_left_d = beats_left_q;
      last_dw_d    = last_dw_q;
      tag_err_d    = 1'b0;
      seq_rd_en    = 1'b0;
      eop_xfer     = 1'b0;
      out_sop      = 1'b0;
      out_eop      = 1'b0;
      out_last_dw  = 2'b00;
      case (state_q)
         IDLE: begin
            if (!seq_empty && !arst) begin
               seq_rd_en = 1'b1;
               state_d   = TAG_WAIT;
            end
         end
         TAG_WAIT: begin
            src_sel_d = seq_rd_data_1;
            if (seq_rd_data_1 == NO_SOURCE) begin
               tag_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = HDR;
            end
         end
         HDR: begin
            if (xfer) begin
               out_sop   = 1'b1;
               last_dw_d = hdr_last_dw;
               if (hdr_beats_left == '0) begin
                  out_eop      = 1'b1;
                  out_last_dw  = hdr_last_dw;
                  beats_left_d = '0;
                  eop_xfer     = 1'b1;
               end else begin
                  beats_left_d = hdr_beats_left;
                  state_d      = DATA;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               beats_left_d = beats_left_q - LEN_WIDTH'(1);
               if (beats_left_q == LEN_WIDTH'(1)) begin
                  out_eop     = 1'b1;
                  out_last_dw = last_dw_q;
                  eop_xfer    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (eop_xfer) begin
`ifdef FRAG_PREFETCH_EN
         // Overlap the next tag pop with the eop transfer to save one bubble.
         if (!seq_empty) begin
            seq_rd_en = 1'b1;
            state_d   = TAG_WAIT;
         end else begin
            state_d = IDLE;
         end
`else
         state_d = IDLE;
`endif
      end

      start_fragment_d = dll.dll_valid && dll.dll_ready && dll.dll_eop;
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q          <= IDLE;
         src_sel_q        <= NO_SOURCE;
         beats_left_q     <= '0;
         last_dw_q        <= 2'b00;
         tag_err_q        <= 1'b0;
         start_fragment_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         src_sel_q        <= src_sel_d;
         beats_left_q     <= beats_left_d;
         last_dw_q        <= last_dw_d;
         tag_err_q        <= tag_err_d;
         start_fragment_q <= start_fragment_d;
      end
   end

   tlp_frag_out_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_stage (
      .clk        (clk),
      .arst       (arst),
      .load       (xfer),
      .in_data    (src_data),
      .in_sop     (out_sop),
      .in_eop     (out_eop),
      .in_last_dw (out_last_dw),
      .dll        (dll)
   );

   assign src_rd_en      = xfer;
   assign src_sel        = src_sel_q;
   assign seq_rd_mode    = arst ? 2'b00 : 2'b01;
   assign tag_err        = tag_err_q;
   assign start_fragment = start_fragment_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_tlp_frag_ctrl.sv
// Directed bench for tlp_frag_ctrl with recorder/source models and a beat scoreboard.
module tb_tlp_frag_ctrl;
   import data_frag_package::*;

   localparam int DW = 128;
   localparam int LW = 11;
   localparam int W  = DW + 4;
`ifdef FRAG_PREFETCH_EN
   localparam int EXP_GAP = 1;
`else
   localparam int EXP_GAP = 2;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   logic                seq_rd_en;
   logic [1:0]          seq_rd_mode;
   Tx_Arbiter_Sources_t seq_rd_data_1 = NO_SOURCE;
   logic                seq_empty;
   Tx_Arbiter_Sources_t src_sel;
   logic                src_rd_en;
   logic                src_valid;
   logic [DW-1:0]       src_data;
   logic [LW-1:0]       src_len;
   logic                start_fragment;
   logic                tag_err;
   frag_state_t         dbg_state;
   logic                dll_ready = 1'b1;
   logic                src_en = 1'b1;

   tlp_frag_ctrl_if #(.DATA_WIDTH(DW)) dll_if ();
   assign dll_if.dll_ready = dll_ready;

   tlp_frag_ctrl #(
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk            (clk),
      .arst           (arst),
      .seq_rd_en      (seq_rd_en),
      .seq_rd_mode    (seq_rd_mode),
      .seq_rd_data_1  (seq_rd_data_1),
      .seq_empty      (seq_empty),
      .src_sel        (src_sel),
      .src_rd_en      (src_rd_en),
      .src_valid      (src_valid),
      .src_data       (src_data),
      .src_len        (src_len),
      .dll            (dll_if),
      .start_fragment (start_fragment),
      .tag_err        (tag_err),
      .dbg_state      (dbg_state)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] exp_q[$];

   // sequence recorder model: registered pop
   Tx_Arbiter_Sources_t tag_mem [0:31];
   int tag_wr = 0;
   int tag_rd = 0;
   assign seq_empty = (tag_rd == tag_wr);
   always @(posedge clk) begin
      if (seq_rd_en) begin
         seq_rd_data_1 <= tag_mem[tag_rd];
         tag_rd        <= tag_rd + 1;
      end
   end

   // source buffer model: FWFT, TLPs served in push order, only for the matching src_sel
   logic [DW-1:0]       beat_mem [0:511];
   int                  tlp_len  [0:31];
   Tx_Arbiter_Sources_t tlp_tag  [0:31];
   int                  tlp_nb   [0:31];
   int n_tlp = 0;
   int beat_wr = 0;
   int rd_tlp = 0;
   int rd_beat = 0;
   int beat_in_tlp = 0;
   assign src_valid = src_en && (rd_tlp < n_tlp) && (src_sel == tlp_tag[rd_tlp]);
   assign src_data  = beat_mem[rd_beat];
   assign src_len   = LW'(tlp_len[rd_tlp]);
   always @(posedge clk) begin
      if (arst) begin
         if (beat_in_tlp != 0) begin
            rd_beat     <= rd_beat + tlp_nb[rd_tlp] - beat_in_tlp;
            rd_tlp      <= rd_tlp + 1;
            beat_in_tlp <= 0;
         end
      end else if (src_rd_en) begin
         rd_beat <= rd_beat + 1;
         if (beat_in_tlp + 1 == tlp_nb[rd_tlp]) begin
            rd_tlp      <= rd_tlp + 1;
            beat_in_tlp <= 0;
         end else begin
            beat_in_tlp <= beat_in_tlp + 1;
         end
      end
   end

   // scoreboard / protocol monitor on the falling edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int acc_cnt = 0;
   int sf_cnt = 0;
   int tag_err_cnt = 0;
   int last_eop_cyc = 0;
   int sop_gap = -1;
   logic prev_acc_eop = 1'b0;
   logic prev_hold = 1'b0;
   logic [W-1:0] prev_bus = '0;
   logic [W-1:0] obs_bus;
   logic [W-1:0] exp_bus;

   always @(negedge clk) begin
      obs_bus = {dll_if.dll_data, dll_if.dll_sop, dll_if.dll_eop, dll_if.dll_last_dw};
      if (dll_if.dll_valid && dll_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL unexpected_beat obs=%h exp=none", obs_bus);
         end else begin
            exp_bus = exp_q.pop_front();
            assert (obs_bus === exp_bus) else begin
               miscompares++;
               $error("FAIL beat obs=%h exp=%h", obs_bus, exp_bus);
            end
         end
         acc_cnt++;
         if (dll_if.dll_sop) sop_gap = cyc - last_eop_cyc - 1;
         if (dll_if.dll_eop) last_eop_cyc = cyc;
      end
      vectors++;
      assert (start_fragment === prev_acc_eop) else begin
         miscompares++;
         $error("FAIL start_fragment obs=%b exp=%b", start_fragment, prev_acc_eop);
      end
      if (prev_hold) begin
         vectors++;
         assert (dll_if.dll_valid === 1'b1 && obs_bus === prev_bus) else begin
            miscompares++;
            $error("FAIL hold obs=%b/%h exp=1/%h", dll_if.dll_valid, obs_bus, prev_bus);
         end
      end
      if (dll_if.dll_valid && !dll_ready) begin
         vectors++;
         assert (src_rd_en === 1'b0) else begin
            miscompares++;
            $error("FAIL rd_en_in_hold obs=%b exp=0", src_rd_en);
         end
      end
      if (src_rd_en) begin
         vectors++;
         assert (src_valid === 1'b1) else begin
            miscompares++;
            $error("FAIL rd_en_no_valid obs=%b exp=1", src_valid);
         end
      end
      if (start_fragment) sf_cnt++;
      if (tag_err) tag_err_cnt++;
      prev_acc_eop = dll_if.dll_valid && dll_ready && dll_if.dll_eop;
      prev_hold    = dll_if.dll_valid && !dll_ready;
      prev_bus     = obs_bus;
   end

   // driver tasks
   logic rand_mode = 1'b0;
   int   exp_sf = 0;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s obs=%0h exp=%0h", name, obs, exp);
      end
   endtask

   task automatic push_tlp(input Tx_Arbiter_Sources_t tag, input int len);
      int nb;
      logic [DW-1:0] d;
      logic [1:0] ldw;
      tag_mem[tag_wr] = tag;
      if (tag != NO_SOURCE) begin
         nb  = (len + 3) / 4;
         ldw = 2'((len - 1) % 4);
         for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            beat_mem[beat_wr] = d;
            beat_wr++;
            exp_q.push_back({d, (b == 0), (b == nb - 1), (b == nb - 1) ? ldw : 2'b00});
         end
         tlp_len[n_tlp] = len;
         tlp_tag[n_tlp] = tag;
         tlp_nb[n_tlp]  = nb;
         n_tlp++;
         exp_sf++;
      end
      tag_wr++;
   endtask

   task automatic drain(input string name, input int budget);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || dbg_state != IDLE || !seq_empty || dll_if.dll_valid)
             && t < budget) begin
         if (rand_mode) begin
            src_en    = 1'($urandom_range(0, 1));
            dll_ready = 1'($urandom_range(0, 1));
         end
         step(1);
         t++;
      end
      src_en    = 1'b1;
      dll_ready = 1'b1;
      step(2);
      vectors++;
      assert (t < budget) else begin
         miscompares++;
         $error("FAIL %s_timeout obs=%0d exp=<%0d", name, t, budget);
      end
   endtask

   initial begin
      int base;
      int t;
      Tx_Arbiter_Sources_t rtag;

      // reset state
      arst = 1'b1;
      step(3);
      chk("rst_seq_rd_en", 64'(seq_rd_en), 0);
      chk("rst_seq_rd_mode", 64'(seq_rd_mode), 0);
      chk("rst_src_sel", 64'(src_sel), 64'(NO_SOURCE));
      chk("rst_src_rd_en", 64'(src_rd_en), 0);
      chk("rst_dll_valid", 64'(dll_if.dll_valid), 0);
      chk("rst_dll_data", 64'(dll_if.dll_data != '0), 0);
      chk("rst_dll_sop_eop", 64'({dll_if.dll_sop, dll_if.dll_eop}), 0);
      chk("rst_dll_last_dw", 64'(dll_if.dll_last_dw), 0);
      chk("rst_start_fragment", 64'(start_fragment), 0);
      chk("rst_tag_err", 64'(tag_err), 0);
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      arst = 1'b0;
      step(1);
      chk("seq_rd_mode", 64'(seq_rd_mode), 64'h1);

      // single-beat TLP: sop=eop, last_dw=2
      push_tlp(PH, 3);
      drain("len3", 50);
      chk("len3_sf_cnt", 64'(sf_cnt), 1);

      // 3-beat TLP, last_dw=3
      base = acc_cnt;
      push_tlp(NPH, 12);
      drain("len12", 50);
      chk("len12_beats", 64'(acc_cnt - base), 3);

      // back-pressure after beat 1
      base = acc_cnt;
      dll_ready = 1'b0;
      push_tlp(CPLD, 9);
      t = 0;
      while (!dll_if.dll_valid && t < 20) begin
         step(1);
         t++;
      end
      chk("bp_first_valid", 64'(dll_if.dll_valid), 1);
      step(5);
      chk("bp_held_sop", 64'(dll_if.dll_sop), 1);
      chk("bp_no_accept", 64'(acc_cnt - base), 0);
      dll_ready = 1'b1;
      drain("len9", 50);
      chk("len9_beats", 64'(acc_cnt - base), 3);

      // NO_SOURCE tag then a normal one
      base = acc_cnt;
      push_tlp(NO_SOURCE, 0);
      push_tlp(PH, 8);
      drain("nosrc", 50);
      chk("tag_err_cnt", 64'(tag_err_cnt), 1);
      chk("after_nosrc_beats", 64'(acc_cnt - base), 2);

      // gap between back-to-back TLPs
      push_tlp(PD, 4);
      push_tlp(PD, 4);
      drain("gap", 50);
      chk("eop_sop_gap", 64'(sop_gap), 64'(EXP_GAP));

      // reset on beat 2 of a 5-beat TLP
      push_tlp(PH, 20);
      t = 0;
      while (!(dll_if.dll_valid && !dll_if.dll_sop) && t < 30) begin
         step(1);
         t++;
      end
      chk("mid_rst_beat2_seen", 64'(dll_if.dll_valid && !dll_if.dll_sop), 1);
      arst = 1'b1;
      step(1);
      chk("mid_rst_dll_valid", 64'(dll_if.dll_valid), 0);
      chk("mid_rst_dll_flags", 64'({dll_if.dll_sop, dll_if.dll_eop, dll_if.dll_last_dw}), 0);
      chk("mid_rst_src_sel", 64'(src_sel), 64'(NO_SOURCE));
      chk("mid_rst_rd_en", 64'({seq_rd_en, src_rd_en}), 0);
      chk("mid_rst_state", 64'(dbg_state), 64'(IDLE));
      chk("mid_rst_pending", 64'(exp_q.size()), 3);
      exp_q.delete();
      exp_sf--;
      arst = 1'b0;
      step(1);
      base = acc_cnt;
      push_tlp(PH, 16);
      drain("post_rst", 60);
      chk("post_rst_beats", 64'(acc_cnt - base), 4);

      // length boundaries
      push_tlp(NPD, 1);
      push_tlp(CPLH, 1032);
      drain("len_bounds", 2000);

      // random lengths with source underflow and DLL back-pressure
      rand_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rtag = Tx_Arbiter_Sources_t'($urandom_range(1, 6));
         push_tlp(rtag, $urandom_range(1, 40));
      end
      drain("random", 3000);
      rand_mode = 1'b0;

      chk("sf_total", 64'(sf_cnt), 64'(exp_sf));
      chk("queue_empty", 64'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
